intersection_scheduler: RTL and testbench

//   Schedules two traffic_light instances (direction A, direction B) that share one intersection.

---
 rtl/intersection_scheduler.sv | 116 +++++++++++
 tb/tb_intersection_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: round-robin owner of a shared intersection for two traffic lights; define PED_EXTEND_EN to lengthen service after a pedestrian request
module intersection_scheduler #(
  parameter int WIDTH   = 16,
  parameter int T_SERVE = 500,
  parameter int T_CLEAR = 50,
  parameter int T_PED   = 200
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic night,
  input  logic req_a,
  input  logic req_b,
  input  logic ped_a,
  input  logic ped_b,
  output logic start_a,
  output logic start_b,
  output logic night_o,
  output logic active_a,
  output logic active_b,
  output logic clear
);
  typedef enum logic [2:0] {IDLE, SERVE_A, SERVE_B, CLEAR, NIGHT} state_t;
  localparam logic [WIDTH-1:0] LD_SERVE = WIDTH'(T_SERVE - 1);
  localparam logic [WIDTH-1:0] LD_PED   = WIDTH'(T_SERVE + T_PED - 1);
  localparam logic [WIDTH-1:0] LD_CLEAR = WIDTH'(T_CLEAR - 1);
  state_t state;
  logic [WIDTH-1:0] timer;
  logic pend_a, pend_b, ped_pend_a, ped_pend_b, last_a, ped_in_a, ped_in_b, go_a;
`ifdef PED_EXTEND_EN
  assign ped_in_a = ped_a;
  assign ped_in_b = ped_b;
`else
  assign ped_in_a = 1'b0;
  assign ped_in_b = 1'b0;
`endif
  assign go_a = pend_a & (~pend_b | ~last_a);
  // Request latching, grant arbitration and service/clearance timing
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      {start_a, start_b, night_o, active_a, active_b, clear} <= '0;
      {pend_a, pend_b, ped_pend_a, ped_pend_b} <= '0;
      last_a     <= 1'b0;
    end else begin
      start_a    <= 1'b0;
      start_b    <= 1'b0;
      pend_a     <= pend_a | req_a | ped_a;
      pend_b     <= pend_b | req_b | ped_b;
      ped_pend_a <= ped_pend_a | ped_in_a;
      ped_pend_b <= ped_pend_b | ped_in_b;
      case (state)
        IDLE: begin
          if (night) begin
            state   <= NIGHT;
            night_o <= 1'b1;
            {pend_a, pend_b, ped_pend_a, ped_pend_b} <= '0;
          end else if (go_a) begin
            state      <= SERVE_A;
            start_a    <= 1'b1;
            active_a   <= 1'b1;
            pend_a     <= 1'b0;
            ped_pend_a <= 1'b0;
            timer      <= ped_pend_a ? LD_PED : LD_SERVE;
          end else if (pend_b) begin
            state      <= SERVE_B;
            start_b    <= 1'b1;
            active_b   <= 1'b1;
            pend_b     <= 1'b0;
            ped_pend_b <= 1'b0;
            timer      <= ped_pend_b ? LD_PED : LD_SERVE;
          end
        end
        SERVE_A: begin
          pend_a     <= 1'b0;
          ped_pend_a <= 1'b0;
          if (timer == '0) begin
            state    <= CLEAR;
            active_a <= 1'b0;
            clear    <= 1'b1;
            timer    <= LD_CLEAR;
            last_a   <= 1'b1;
          end else
            timer <= timer - 1'b1;
        end
        SERVE_B: begin
          pend_b     <= 1'b0;
          ped_pend_b <= 1'b0;
          if (timer == '0) begin
            state    <= CLEAR;
            active_b <= 1'b0;
            clear    <= 1'b1;
            timer    <= LD_CLEAR;
            last_a   <= 1'b0;
          end else
            timer <= timer - 1'b1;
        end
        CLEAR: begin
          if (timer == '0) begin
            state <= IDLE;
            clear <= 1'b0;
          end else
            timer <= timer - 1'b1;
        end
        NIGHT: begin
          {pend_a, pend_b, ped_pend_a, ped_pend_b} <= '0;
          if (!night) begin
            state   <= IDLE;
            night_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: vector table plus grant scoreboard for intersection_scheduler
module tb_intersection_scheduler;
  localparam int T_SERVE = 8;
  localparam int T_CLEAR = 3;
  localparam int T_PED   = 4;
  localparam int WIDTH   = 8;
`ifdef PED_EXTEND_EN
  localparam int PED_LEN = T_SERVE + T_PED;
`else
  localparam int PED_LEN = T_SERVE;
`endif
  localparam int B_SA = 5, B_SB = 4, B_AA = 2, B_AB = 1, B_CL = 0;
  logic clk50m = 1'b0, rst_n = 1'b0, night = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, ped_a = 1'b0, ped_b = 1'b0;
  logic start_a, start_b, night_o, active_a, active_b, clear;
  int n_chk = 0, n_pass = 0, cyc = 0, overlap = 0, len;
  int sb[$];
  int starts_t[$];
  typedef struct {
    logic r, n, ra, rb, pa, pb;
    logic [5:0] e;
    int g;
  } vec_t;
  vec_t vecs[$];

  intersection_scheduler #(.WIDTH(WIDTH), .T_SERVE(T_SERVE), .T_CLEAR(T_CLEAR), .T_PED(T_PED)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .night(night), .req_a(req_a), .req_b(req_b),
    .ped_a(ped_a), .ped_b(ped_b), .start_a(start_a), .start_b(start_b), .night_o(night_o),
    .active_a(active_a), .active_b(active_b), .clear(clear)
  );

  always #10 clk50m = ~clk50m;
  always @(posedge clk50m) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {start_a, start_b, night_o, active_a, active_b, clear};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic reset_dut();
    {night, req_a, req_b, ped_a, ped_b} = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_len(input int b, output int n);
    logic [5:0] o;
    n = 0;
    o = outs();
    while (o[b] === 1'b1 && n < 100) begin
      n++;
      tick();
      o = outs();
    end
  endtask

  task automatic wait_for(input int b, input string name);
    logic [5:0] o;
    o = outs();
    for (int i = 0; i < 60 && o[b] !== 1'b1; i++) begin
      tick();
      o = outs();
    end
    check(name, int'(o[b]), 1);
  endtask

  task automatic add(input logic r, n, ra, rb, pa, pb, input logic [5:0] e, input int g);
    vec_t v;
    v.r = r; v.n = n; v.ra = ra; v.rb = rb; v.pa = pa; v.pb = pb; v.e = e; v.g = g;
    vecs.push_back(v);
  endtask

  // Grant scoreboard and exclusivity monitor, sampled mid-cycle
  always @(negedge clk50m) begin
    if (active_a === 1'b1 && active_b === 1'b1) overlap++;
    if (start_a === 1'b1 || start_b === 1'b1) begin
      starts_t.push_back(cyc);
      if (sb.size() == 0) check("grant_unexpected", start_a ? 1 : 2, 0);
      else check("grant_dir", start_a ? 1 : 2, sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    add(0, 0, 1, 0, 0, 0, 6'b000000, 0);
    add(0, 0, 1, 0, 0, 0, 6'b000000, 0);
    add(1, 0, 1, 0, 0, 0, 6'b000000, 1);
    add(1, 0, 0, 0, 0, 0, 6'b100100, 0);
    repeat (T_SERVE - 1) add(1, 0, 0, 0, 0, 0, 6'b000100, 0);
    repeat (T_CLEAR) add(1, 0, 0, 0, 0, 0, 6'b000001, 0);
    repeat (2) add(1, 0, 0, 0, 0, 0, 6'b000000, 0);
    foreach (vecs[i]) begin
      {rst_n, night, req_a, req_b, ped_a, ped_b} =
        {vecs[i].r, vecs[i].n, vecs[i].ra, vecs[i].rb, vecs[i].pa, vecs[i].pb};
      if (vecs[i].g != 0) sb.push_back(vecs[i].g);
      tick();
      check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].e));
    end

    reset_dut();
    req_a = 1'b1;
    req_b = 1'b1;
    sb.push_back(1); sb.push_back(2); sb.push_back(1); sb.push_back(2);
    starts_t.delete();
    for (int i = 0; i < 80 && starts_t.size() < 4; i++) tick();
    check("tie_grants", starts_t.size(), 4);
    if (starts_t.size() >= 4)
      for (int i = 1; i < 4; i++) check($sformatf("tie_gap%0d", i), starts_t[i] - starts_t[i-1], 12);

    reset_dut();
    req_a = 1'b1;
    sb.push_back(1);
    tick();
    req_a = 1'b0;
    tick();
    check("night_start_a", int'(start_a), 1);
    len = 0;
    for (int k = 0; k < 40 && active_a === 1'b1; k++) begin
      len++;
      if (k == 2) begin night = 1'b1; req_b = 1'b1; end
      if (k == 3) req_b = 1'b0;
      tick();
    end
    check("night_serve_len", len, T_SERVE);
    run_len(B_CL, len);
    check("night_clear_len", len, T_CLEAR);
    tick();
    check("night_o_on", int'(night_o), 1);
    night = 1'b0;
    tick();
    check("night_o_off", int'(night_o), 0);
    repeat (4) tick();
    check("night_pend_b_dropped", int'(outs()), 0);

    reset_dut();
    req_a = 1'b1;
    sb.push_back(1);
    tick();
    req_a = 1'b0;
    tick();
    check("own_start_a", int'(start_a), 1);
    len = 0;
    for (int k = 0; k < 40 && active_a === 1'b1; k++) begin
      len++;
      req_a = (k == 1 || k == 5);
      tick();
    end
    req_a = 1'b0;
    check("own_serve_len", len, T_SERVE);
    run_len(B_CL, len);
    check("own_clear_len", len, T_CLEAR);
    repeat (10) tick();
    check("own_no_regrant", int'(outs()), 0);

    reset_dut();
    ped_b = 1'b1;
    sb.push_back(2);
    tick();
    ped_b = 1'b0;
    tick();
    check("ped_start_b", int'(start_b), 1);
    run_len(B_AB, len);
    check("ped_serve_len", len, PED_LEN);
    run_len(B_CL, len);
    check("ped_clear_len", len, T_CLEAR);

    reset_dut();
    req_a = 1'b1;
    sb.push_back(1);
    tick();
    req_a = 1'b0;
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    check("mid_start_a", int'(start_a), 1);
    wait_for(B_CL, "mid_clear_reached");
    rst_n = 1'b0;
    tick();
    check("mid_reset_outs", int'(outs()), 0);
    rst_n = 1'b1;
    repeat (8) tick();
    check("mid_reset_no_grant", int'(outs()), 0);

    check("sb_drained", sb.size(), 0);
    check("never_both_active", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
